seq_bin_to_bcd: RTL and testbench
=================================

SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 The block SHALL have parameter DONE_PULSE, default 1; 1 means done is a one-cycle pulse, 0 means done is held until the next accepted start or reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request.
REQ-005 The block SHALL have port bin, input, 8 bits: binary value to convert, normally the add/sub result register S.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: request sign-magnitude conversion (see Configuration).
REQ-007 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 The block SHALL have port done, output, 1 bit: result valid indication.
REQ-009 The block SHALL have ports bcd2, bcd1, bcd0, outputs, 4 bits each: registered hundreds, tens and units digits, feeding the 7-seg decoders.
REQ-010 The block SHALL have port neg, output, 1 bit: registered sign of the result.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, CONVERT and FINISH.
REQ-012 In IDLE, start=1 at a rising edge (E0) SHALL capture bin into an internal 20-bit shift register (12 BCD bits cleared), clear the iteration counter and enter CONVERT.
REQ-013 Any change on bin after E0 SHALL NOT affect the conversion in progress.
REQ-014 In CONVERT, each edge SHALL perform one double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the whole register left by 1.
REQ-015 Exactly 8 iterations SHALL occur (edges E1..E8); at E8 the FSM SHALL enter FINISH.
REQ-016 At E9 (in FINISH), bcd2/bcd1/bcd0/neg SHALL load from the shift register and the FSM SHALL return to IDLE.
REQ-017 Latency from the start edge to the output update SHALL be 9 clocks.
REQ-018 busy SHALL be 1 from after E0 until after E9, and 0 otherwise.
REQ-019 With DONE_PULSE=1, done SHALL be 1 for exactly the cycle after E9.
REQ-020 With DONE_PULSE=0, done SHALL stay 1 after E9 until the next accepted start edge, where it clears.
REQ-021 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-022 start held high continuously SHALL be accepted again on the edge after E9 (the first IDLE edge), giving back-to-back conversions every 10 clocks.
REQ-023 Digit outputs SHALL hold their last result between conversions and during a conversion.
REQ-024 Outputs SHALL always be valid BCD: each digit 0..9 and bcd2 <= 2.

Reset
REQ-025 reset=0 SHALL immediately, regardless of clk, force state IDLE, busy=0, done=0, neg=0, bcd2=bcd1=bcd0=0, and clear the shift register and counter.
REQ-026 Reset asserted mid-conversion SHALL abort it with no output update; the first start after reset release SHALL begin a fresh conversion.

Configuration
REQ-027 The only compile-time option SHALL be macro SEQ_BIN_TO_BCD_SIGNED_EN.
REQ-028 With SEQ_BIN_TO_BCD_SIGNED_EN defined, if signed_mode=1 and bin[7]=1 at E0, the block SHALL convert (256 - bin) truncated to 8 bits and set neg=1 at E9; otherwise it SHALL convert bin unchanged and set neg=0.
REQ-029 With SEQ_BIN_TO_BCD_SIGNED_EN defined, bin=128 with signed_mode=1 SHALL yield neg=1, digits 1,2,8.
REQ-030 Without the macro, signed_mode SHALL be ignored, neg SHALL be constant 0, and bin SHALL always be converted as unsigned.
REQ-031 The port list SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL cover: bin=255, start pulse -> busy high for 9 cycles; after E9 digits 2,5,5, done=1 for one cycle.
REQ-033 The bench SHALL cover: bin=0 then bin=9 then bin=10 then bin=99 then bin=100 -> digits 0,0,0 / 0,0,9 / 0,1,0 / 0,9,9 / 1,0,0.
REQ-034 The bench SHALL cover: start at E0 with bin=200, bin changed to 7 and start re-pulsed at E4 -> result 2,0,0; second start ignored; done pulses once.
REQ-035 The bench SHALL cover: reset driven low at E5 of a conversion of 173 -> outputs 0 immediately, busy=0, no done; next start with 42 -> 0,4,2.
REQ-036 The bench SHALL cover: macro defined, signed_mode=1, bin=8'hF6 -> neg=1, digits 0,1,0; macro undefined, same stimulus -> neg=0, digits 2,4,6.
REQ-037 The bench SHALL cover: DONE_PULSE=0 with start held high continuously -> conversions every 10 clocks; done cleared at each accepted start edge.

Source files
------------

// File: rtl/seq_bin_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, 9-clock latency, start ignored while busy).
// Optional sign-magnitude input handling is enabled by defining SEQ_BIN_TO_BCD_SIGNED_EN.
module seq_bin_to_bcd #(
  parameter int DONE_PULSE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  input  logic       signed_mode,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       neg
);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t      state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic        neg_q, neg_d;
  logic [3:0]  bcd2_q, bcd2_d;
  logic [3:0]  bcd1_q, bcd1_d;
  logic [3:0]  bcd0_q, bcd0_d;
  logic [7:0]  mag;
  logic        neg_cap;
  logic [19:0] adj;

  // Magnitude and sign captured at the start edge.
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
  always_comb begin
    mag     = bin;
    neg_cap = 1'b0;
    if (signed_mode && bin[7]) begin
      mag     = 8'd0 - bin;
      neg_cap = 1'b1;
    end
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign mag     = bin;
  assign neg_cap = 1'b0;
`endif

  always_comb begin
    adj = shift_q;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = (DONE_PULSE != 0) ? 1'b0 : done_q;
    neg_d   = neg_q;
    bcd2_d  = bcd2_q;
    bcd1_d  = bcd1_q;
    bcd0_d  = bcd0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {12'd0, mag};
          cnt_d   = 3'd0;
          sign_d  = neg_cap;
          done_d  = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        shift_d = {adj[18:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = FINISH;
      end
      FINISH: begin
        bcd2_d  = shift_q[19:16];
        bcd1_d  = shift_q[15:12];
        bcd0_d  = shift_q[11:8];
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= 20'd0;
      cnt_q   <= 3'd0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd2_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd0_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      bcd2_q  <= bcd2_d;
      bcd1_q  <= bcd1_d;
      bcd0_q  <= bcd0_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign neg  = neg_q;
  assign bcd2 = bcd2_q;
  assign bcd1 = bcd1_q;
  assign bcd0 = bcd0_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: pulsed-done instance for directed vectors, held-done instance for back-to-back runs.
module tb_seq_bin_to_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, sm0, busy0, done0, neg0;
  logic [7:0] bin0;
  logic [3:0] h0, t0, u0d;
  logic       start1, sm1, busy1, done1, neg1;
  logic [7:0] bin1;
  logic [3:0] h1, t1, u1d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [12:0] last0;
  logic [12:0] e0, e1;
  logic        done1_prev = 1'b0;
  int          acc_cyc[3];

  seq_bin_to_bcd #(.DONE_PULSE(1)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .bin(bin0), .signed_mode(sm0),
    .busy(busy0), .done(done0), .bcd2(h0), .bcd1(t0), .bcd0(u0d), .neg(neg0)
  );

  seq_bin_to_bcd #(.DONE_PULSE(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .bin(bin1), .signed_mode(sm1),
    .busy(busy1), .done(done1), .bcd2(h1), .bcd1(t1), .bcd0(u1d), .neg(neg1)
  );

  always @(posedge clk) cyc++;

  function automatic logic [12:0] res(input logic n, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    return {n, h, t, u};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: one pop per result presentation.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0_unexpected_done: got %0h expected no done", {neg0, h0, t0, u0d});
      end else begin
        e0 = q0.pop_front();
        chk("u0_result", {19'd0, neg0, h0, t0, u0d}, {19'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1_unexpected_done: got %0h expected no done", {neg1, h1, t1, u1d});
      end else begin
        e1 = q1.pop_front();
        chk("u1_result", {19'd0, neg1, h1, t1, u1d}, {19'd0, e1});
      end
    end
    done1_prev = done1;
  end

  // mode 0: plain conversion, 1: start re-pulsed mid-conversion, 2: reset at E5
  task automatic run0(input logic [7:0] v, input logic sm, input int mode, input logic [12:0] exp);
    int n;
    int nbusy;
    int ndone;
    @(posedge clk);
    #1;
    start0 = 1'b1;
    bin0   = v;
    sm0    = sm;
    if (mode != 2) q0.push_back(exp);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    bin0   = 8'd7;
    nbusy  = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mode == 1 && n == 3) start0 = 1'b1;
      if (mode == 1 && n == 4) start0 = 1'b0;
      if (n == 4) chk("hold_during_conv", {19'd0, neg0, h0, t0, u0d}, {19'd0, last0});
      if (mode == 2 && n == 5) begin
        rst_n = 1'b0;
        #1;
        chk("abort_digits", {19'd0, neg0, h0, t0, u0d}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        break;
      end
      if (done0) break;
      if (busy0) nbusy++;
    end
    if (mode != 2) begin
      chk("done_latency", n, 10);
      chk("busy_cycles", nbusy, 9);
      @(negedge clk);
      chk("done_pulse_width", {31'd0, done0}, 32'd0);
      chk("busy_after_done", {31'd0, busy0}, 32'd0);
      last0 = exp;
    end else begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last0 = 13'd0;
      ndone = 0;
      repeat (12) begin
        @(negedge clk);
        if (done0 || busy0) ndone++;
      end
      chk("abort_no_resume", ndone, 0);
    end
  endtask

  initial begin
    int n;
    int accepts;
    logic pb;
    rst_n = 1'b0;
    start0 = 1'b0; bin0 = 8'd0; sm0 = 1'b0;
    start1 = 1'b0; bin1 = 8'd0; sm1 = 1'b0;
    last0 = 13'd0;
    #12;
    chk("reset_u0", {17'd0, busy0, done0, neg0, h0, t0, u0d}, 32'd0);
    chk("reset_u1", {17'd0, busy1, done1, neg1, h1, t1, u1d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run0(8'd255, 1'b0, 0, res(1'b0, 4'd2, 4'd5, 4'd5));
    run0(8'd0,   1'b0, 0, res(1'b0, 4'd0, 4'd0, 4'd0));
    run0(8'd9,   1'b0, 0, res(1'b0, 4'd0, 4'd0, 4'd9));
    run0(8'd10,  1'b0, 0, res(1'b0, 4'd0, 4'd1, 4'd0));
    run0(8'd99,  1'b0, 0, res(1'b0, 4'd0, 4'd9, 4'd9));
    run0(8'd100, 1'b0, 0, res(1'b0, 4'd1, 4'd0, 4'd0));
    run0(8'd200, 1'b0, 1, res(1'b0, 4'd2, 4'd0, 4'd0));
    run0(8'd173, 1'b0, 2, 13'd0);
    run0(8'd42,  1'b0, 0, res(1'b0, 4'd0, 4'd4, 4'd2));
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    run0(8'hF6,  1'b1, 0, res(1'b1, 4'd0, 4'd1, 4'd0));
    run0(8'd128, 1'b1, 0, res(1'b1, 4'd1, 4'd2, 4'd8));
    run0(8'hF6,  1'b0, 0, res(1'b0, 4'd2, 4'd4, 4'd6));
`else
    run0(8'hF6,  1'b1, 0, res(1'b0, 4'd2, 4'd4, 4'd6));
    run0(8'd128, 1'b1, 0, res(1'b0, 4'd1, 4'd2, 4'd8));
`endif

    // Held-done instance: single run, then start held high for back-to-back runs.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    bin1   = 8'd37;
    q1.push_back(res(1'b0, 4'd0, 4'd3, 4'd7));
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done1) break;
    end
    chk("u1_done_seen", {31'd0, done1}, 32'd1);
    repeat (5) @(negedge clk);
    chk("u1_done_held", {31'd0, done1}, 32'd1);

    @(posedge clk);
    #1;
    start1 = 1'b1;
    bin1   = 8'd128;
    q1.push_back(res(1'b0, 4'd1, 4'd2, 4'd8));
    accepts = 0;
    pb = busy1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy1 && !pb) begin
        acc_cyc[accepts] = cyc;
        chk("u1_done_clr_at_start", {31'd0, done1}, 32'd0);
        accepts++;
        if (accepts == 1) begin
          bin1 = 8'd250;
          q1.push_back(res(1'b0, 4'd2, 4'd5, 4'd0));
        end else if (accepts == 2) begin
          bin1 = 8'd5;
          q1.push_back(res(1'b0, 4'd0, 4'd0, 4'd5));
        end else begin
          start1 = 1'b0;
          break;
        end
      end
      pb = busy1;
    end
    chk("u1_accept_count", accepts, 3);
    if (accepts == 3) begin
      chk("u1_period_a", acc_cyc[1] - acc_cyc[0], 10);
      chk("u1_period_b", acc_cyc[2] - acc_cyc[1], 10);
    end
    repeat (15) @(negedge clk);

    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
